// File: rtl/utm_tape_controller_if.sv
// Core-side handshake of the UTM tape controller: symbol strobe out, core response in.
// master = tape controller, slave = UTM core.
interface utm_tape_controller_if #(
  parameter int unsigned SYM_W = 3
);
  logic [SYM_W-1:0] sym_out;
  logic             sym_valid;
  logic             core_rst;
  logic [SYM_W-1:0] new_sym;
  logic             direction;

  modport master (output sym_out, sym_valid, core_rst, input new_sym, direction);
  modport slave  (input sym_out, sym_valid, core_rst, output new_sym, direction);
endinterface

// File: rtl/utm_tape_controller.sv
// Tape register array and step sequencer for the UTM core, with host load/readback port.
// Optional step limit (max_steps/step_count ports) enabled by defining UTM_STEP_LIMIT_EN.
module utm_tape_controller #(
  parameter int unsigned           ADDR_W = 6,
  parameter int unsigned           SYM_W  = 3,
  parameter logic [SYM_W-1:0]      BLANK  = 3'b000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [ADDR_W-1:0]        start_head,
  input  logic                     ld_we,
  input  logic [ADDR_W-1:0]        ld_addr,
  input  logic [SYM_W-1:0]         ld_data,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [SYM_W-1:0]         rd_data,
  utm_tape_controller_if.master    core,
  output logic                     busy,
  output logic                     halted,
  output logic                     fault,
  output logic [ADDR_W-1:0]        head
`ifdef UTM_STEP_LIMIT_EN
  ,
  input  logic [15:0]              max_steps,
  output logic [15:0]              step_count
`endif
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, CRST, FETCH, EXEC, HALT} state_t;

  state_t              state, state_n;
  logic [SYM_W-1:0]    tape [DEPTH];
  logic [ADDR_W-1:0]   head_n;
  logic                fault_n;
  logic                stop_pend, stop_pend_n;
  logic                tape_we;
  logic [ADDR_W-1:0]   tape_wa;
  logic [SYM_W-1:0]    tape_wd;
  logic                at_edge;
  logic                limit_hit;

`ifdef UTM_STEP_LIMIT_EN
  logic [15:0] step_n;

  always_comb begin
    step_n = step_count;
    case (state)
      CRST:    step_n = '0;
      EXEC:    if (step_count != '1) step_n = step_count + 16'd1;
      default: ;
    endcase
  end

  assign limit_hit = (max_steps != '0) && (step_n == max_steps);

  always_ff @(posedge clock) begin
    if (reset) step_count <= '0;
    else       step_count <= step_n;
  end
`else
  assign limit_hit = 1'b0;
`endif

  assign at_edge = core.direction ? (head == '1) : (head == '0);

  always_comb begin
    state_n     = state;
    head_n      = head;
    fault_n     = fault;
    stop_pend_n = stop_pend;
    tape_we     = 1'b0;
    tape_wa     = head;
    tape_wd     = core.new_sym;
    case (state)
      IDLE, HALT: begin
        tape_we = ld_we;
        tape_wa = ld_addr;
        tape_wd = ld_data;
        if (start) begin
          state_n = CRST;
          head_n  = start_head;
        end
      end
      CRST: begin
        fault_n     = 1'b0;
        stop_pend_n = 1'b0;
        state_n     = FETCH;
      end
      FETCH: begin
        if (stop) stop_pend_n = 1'b1;
        state_n = EXEC;
      end
      EXEC: begin
        tape_we     = 1'b1;
        stop_pend_n = 1'b0;
        if (at_edge) begin
          fault_n = 1'b1;
          state_n = HALT;
        end else begin
          head_n  = core.direction ? head + ADDR_W'(1) : head - ADDR_W'(1);
          state_n = (stop || stop_pend || limit_hit) ? HALT : FETCH;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // sym_out/sym_valid are registered on entry to FETCH so both are stable for the whole
  // FETCH cycle; the entry read never aliases the EXEC write because the head always moves.
  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      head           <= '0;
      fault          <= 1'b0;
      stop_pend      <= 1'b0;
      core.sym_out   <= '0;
      core.sym_valid <= 1'b0;
    end else begin
      state          <= state_n;
      head           <= head_n;
      fault          <= fault_n;
      stop_pend      <= stop_pend_n;
      core.sym_valid <= (state_n == FETCH);
      if (state_n == FETCH) core.sym_out <= tape[head_n];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) tape[i] <= BLANK;
      rd_data <= '0;
    end else begin
      if (tape_we) tape[tape_wa] <= tape_wd;
      rd_data <= tape[rd_addr];
    end
  end

  assign core.core_rst = (state == IDLE) || (state == CRST);
  assign busy          = (state == CRST) || (state == FETCH) || (state == EXEC);
  assign halted        = (state == HALT);

endmodule

// File: tb/tb_utm_tape_controller.sv
// Self-checking bench for utm_tape_controller: directed scenarios plus randomized traffic
// compared every cycle against a behavioural tape/run model.
module tb_utm_tape_controller;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop  = 1'b0;
  logic [5:0] start_head = '0;
  logic       ld_we = 1'b0;
  logic [5:0] ld_addr = '0;
  logic [2:0] ld_data = '0;
  logic [5:0] rd_addr = '0;
  logic [2:0] rd_data;
  logic       busy, halted, fault;
  logic [5:0] head;
`ifdef UTM_STEP_LIMIT_EN
  logic [15:0] max_steps = '0;
  logic [15:0] step_count;
`endif

  int total = 0;
  int bad   = 0;

  utm_tape_controller_if #(.SYM_W(3)) core_if ();

  utm_tape_controller #(.ADDR_W(6), .SYM_W(3), .BLANK(3'b000)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .start_head(start_head),
    .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .core(core_if), .busy(busy), .halted(halted), .fault(fault), .head(head)
`ifdef UTM_STEP_LIMIT_EN
    , .max_steps(max_steps), .step_count(step_count)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 running, 2 halted; within a run, cycle 0 is the
  // core-reset cycle, then odd cycles present a symbol and even cycles take the response.
  logic [2:0] tape_m [64];
  int         mode_m = 0;
  int         cyc_m  = 0;
  int         head_m = 0;
  bit         fault_m = 0, stopreq_m = 0, valid_m = 0;
  logic [2:0] sym_m = '0, rd_m = '0;
  int         steps_m = 0;

  always @(posedge clock) begin
    logic [2:0] rd_next;
    int         np;
    bit         lim;
    rd_next = tape_m[rd_addr];
    if (reset) begin
      for (int i = 0; i < 64; i++) tape_m[i] = '0;
      mode_m = 0; cyc_m = 0; head_m = 0; fault_m = 0; stopreq_m = 0;
      valid_m = 0; sym_m = '0; rd_m = '0; steps_m = 0;
    end else begin
      rd_m    = rd_next;
      valid_m = 0;
      if (mode_m != 1) begin
        if (ld_we) tape_m[ld_addr] = ld_data;
        if (start) begin
          mode_m = 1; cyc_m = 0; head_m = int'(start_head);
        end
      end else if (cyc_m == 0) begin
        fault_m = 0; stopreq_m = 0; steps_m = 0; cyc_m = 1;
        valid_m = 1; sym_m = tape_m[head_m];
      end else if (cyc_m % 2 == 1) begin
        if (stop) stopreq_m = 1;
        cyc_m++;
      end else begin
        tape_m[head_m] = core_if.new_sym;
        if (steps_m < 65535) steps_m++;
        lim = 0;
`ifdef UTM_STEP_LIMIT_EN
        lim = (max_steps != 0) && (steps_m == int'(max_steps));
`endif
        np = head_m + (core_if.direction ? 1 : -1);
        if (np < 0 || np > 63) begin
          fault_m = 1; mode_m = 2;
        end else begin
          head_m = np;
          if (stop || stopreq_m || lim) mode_m = 2;
          else begin
            cyc_m++; valid_m = 1; sym_m = tape_m[head_m];
          end
        end
        stopreq_m = 0;
      end
    end
  end

  always @(negedge clock) begin
    if ($time > 6) begin
      check("rd_data", 32'(rd_data), 32'(rd_m));
      check("sym_valid", 32'(core_if.sym_valid), 32'(valid_m));
      check("sym_out", 32'(core_if.sym_out), 32'(sym_m));
      check("core_rst", 32'(core_if.core_rst), 32'(mode_m == 0 || (mode_m == 1 && cyc_m == 0)));
      check("busy", 32'(busy), 32'(mode_m == 1));
      check("halted", 32'(halted), 32'(mode_m == 2));
      check("fault", 32'(fault), 32'(fault_m));
      check("head", 32'(head), 32'(head_m));
`ifdef UTM_STEP_LIMIT_EN
      check("step_count", 32'(step_count), 32'(steps_m));
`endif
    end
  end

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!core_if.sym_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    check({nm, "_valid_seen"}, 32'(core_if.sym_valid), 32'd1);
  endtask

  task automatic run_to_halt(input string nm, output int pulses);
    int n = 0;
    pulses = 0;
    while (!halted && n < 200) begin
      if (core_if.sym_valid) pulses++;
      @(negedge clock);
      n++;
    end
    check({nm, "_halt_seen"}, 32'(halted), 32'd1);
  endtask

  task automatic do_start(input logic [5:0] h, input logic [2:0] ns, input logic dir);
    @(negedge clock);
    start = 1'b1; start_head = h; core_if.new_sym = ns; core_if.direction = dir;
    @(negedge clock);
    start = 1'b0;
  endtask

  initial begin
    int pulses;
    core_if.new_sym = '0;
    core_if.direction = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // reset contents and status
    check("rst_core_rst", 32'(core_if.core_rst), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    for (int a = 0; a < 64; a++) begin
      rd_addr = 6'(a);
      @(negedge clock);
      check("rst_cell", 32'(rd_data), 32'd0);
    end

    // load tape[5]=2, run right writing 7
    @(negedge clock);
    ld_we = 1'b1; ld_addr = 6'd5; ld_data = 3'b010;
    @(negedge clock);
    ld_we = 1'b0;
    do_start(6'd5, 3'b111, 1'b1);
    wait_valid("t2");
    check("t2_sym_out", 32'(core_if.sym_out), 32'd2);
    rd_addr = 6'd5;
    @(negedge clock);
    @(negedge clock);
    check("t2_head", 32'(head), 32'd6);
    check("t2_fetch2_valid", 32'(core_if.sym_valid), 32'd1);
    check("t2_fetch2_sym", 32'(core_if.sym_out), 32'd0);
    stop = 1'b1;
    @(negedge clock);
    check("t2_tape5", 32'(rd_data), 32'd7);
    @(negedge clock);
    stop = 1'b0;
    check("t2_halted", 32'(halted), 32'd1);

    // left move from cell 0 faults
    do_start(6'd0, 3'b101, 1'b0);
    run_to_halt("t3", pulses);
    check("t3_pulses", 32'(pulses), 32'd1);
    check("t3_fault", 32'(fault), 32'd1);
    check("t3_head", 32'(head), 32'd0);
    rd_addr = 6'd0;
    @(negedge clock);
    check("t3_tape0", 32'(rd_data), 32'd5);

    // stop pulsed only during FETCH
    do_start(6'd10, 3'b001, 1'b1);
    wait_valid("t4");
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    rd_addr = 6'd10;
    @(negedge clock);
    check("t4_halted", 32'(halted), 32'd1);
    check("t4_head", 32'(head), 32'd11);
    check("t4_fault", 32'(fault), 32'd0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (core_if.sym_valid) pulses++;
    end
    check("t4_no_more_valid", 32'(pulses), 32'd0);
    check("t4_tape10", 32'(rd_data), 32'd1);

    // host write ignored while busy, honoured in HALT
    do_start(6'd20, 3'b011, 1'b1);
    wait_valid("t5");
    ld_we = 1'b1; ld_addr = 6'd9; ld_data = 3'b110;
    @(negedge clock);
    ld_we = 1'b0; stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    rd_addr = 6'd9;
    @(negedge clock);
    check("t5_busy_write_dropped", 32'(rd_data), 32'd0);
    ld_we = 1'b1;
    @(negedge clock);
    ld_we = 1'b0;
    @(negedge clock);
    check("t5_halt_write", 32'(rd_data), 32'd6);

`ifdef UTM_STEP_LIMIT_EN
    max_steps = 16'd4;
    do_start(6'd0, 3'b010, 1'b1);
    run_to_halt("t6", pulses);
    check("t6_steps", 32'(step_count), 32'd4);
    check("t6_head", 32'(head), 32'd4);
    check("t6_fault", 32'(fault), 32'd0);
    check("t6_pulses", 32'(pulses), 32'd4);
    max_steps = 16'd0;
`endif

    // randomized traffic, checked by the per-cycle model
    for (int c = 0; c < 5000; c++) begin
      @(negedge clock);
      reset      = ($urandom_range(0, 399) == 0);
      start      = ($urandom_range(0, 7) == 0);
      stop       = ($urandom_range(0, 13) == 0);
      start_head = 6'($urandom);
      ld_we      = ($urandom_range(0, 3) == 0);
      ld_addr    = 6'($urandom);
      ld_data    = 3'($urandom);
      rd_addr    = 6'($urandom);
      core_if.new_sym   = 3'($urandom);
      core_if.direction = 1'($urandom);
`ifdef UTM_STEP_LIMIT_EN
      if (start) max_steps = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(1, 6)) : 16'd0;
`endif
    end
    @(negedge clock);
    reset = 1'b0; start = 1'b0; stop = 1'b0; ld_we = 1'b0;
    repeat (3) @(negedge clock);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
